// File: rtl/deint_sel_gen.sv
// deint_sel_gen: write-side sequencer and frame buffer for the ROWS x COLS
// block deinterleaver.
//
// Bits arrive serially on din under din_valid/din_ready. Each accepted bit
// is stored at its permuted slot p(k) = (k mod ROWS)*COLS + (k div ROWS).
// sel presents p(k)+1 to the slot-enable decoder in the same cycle, and is
// 0 when nothing is being written. When a full frame of N = ROWS*COLS bits
// has been stored, the buffer is read out in slot order 0..N-1 under
// dout_valid/dout_ready. Writes and reads never overlap.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   din        in   serial input bit
//   din_valid  in   din is valid this cycle
//   bypass     in   (DEINT_BYPASS_EN only) 1 = identity mapping p(k)=k
//   din_ready  out  block accepts din this cycle (WRITE state)
//   sel        out  slot select, slot+1 (1..N); 0 = no write
//   dout       out  deinterleaved output bit
//   dout_valid out  dout is valid (READ state)
//   dout_ready in   consumer accepts dout
//   frame_done out  one-cycle pulse after the last read handshake of a frame
//
// Optional feature: define DEINT_BYPASS_EN to add the bypass input.
// ROWS*COLS must be <= 15 so that slot+1 fits in the 4-bit sel.
module deint_sel_gen #(
  parameter int ROWS = 3,
  parameter int COLS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
`ifdef DEINT_BYPASS_EN
  input  logic       bypass,
`endif
  output logic       din_ready,
  output logic [3:0] sel,
  output logic       dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       frame_done
);

  localparam int N  = ROWS * COLS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] COLS_W    = CW'(COLS);
  localparam logic [CW-1:0] ROWS_LAST = CW'(ROWS - 1);
  localparam logic [CW-1:0] N_LAST    = CW'(N - 1);

  localparam logic [0:0] S_WRITE = 1'b0;
  localparam logic [0:0] S_READ  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] wrow;   // wcnt mod ROWS, tracked incrementally
  logic [CW-1:0] wcol;   // wcnt div ROWS, tracked incrementally
  logic [CW-1:0] rcnt;
  logic [N-1:0]  buffer;

  logic [CW-1:0] perm_slot;
  logic [CW-1:0] wr_slot;
  logic          write_en;

  // Row/column counters avoid a divider: p(k) = row*COLS + col.
  always_comb begin
    perm_slot = wrow * COLS_W + wcol;
`ifdef DEINT_BYPASS_EN
    wr_slot = bypass ? wcnt : perm_slot;
`else
    wr_slot = perm_slot;
`endif
    write_en   = (state == S_WRITE) && din_valid;
    din_ready  = (state == S_WRITE);
    dout_valid = (state == S_READ);
    sel        = write_en ? (4'(wr_slot) + 4'd1) : 4'd0;
    dout       = buffer[rcnt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_WRITE;
      wcnt       <= '0;
      wrow       <= '0;
      wcol       <= '0;
      rcnt       <= '0;
      buffer     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == S_WRITE) begin
        if (din_valid) begin
          buffer[wr_slot] <= din;
          if (wcnt == N_LAST) begin
            wcnt  <= '0;
            wrow  <= '0;
            wcol  <= '0;
            state <= S_READ;
          end else begin
            wcnt <= wcnt + CW'(1);
            if (wrow == ROWS_LAST) begin
              wrow <= '0;
              wcol <= wcol + CW'(1);
            end else begin
              wrow <= wrow + CW'(1);
            end
          end
        end
      end else begin
        if (dout_ready) begin
          if (rcnt == N_LAST) begin
            rcnt       <= '0;
            state      <= S_WRITE;
            frame_done <= 1'b1;
          end else begin
            rcnt <= rcnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_deint_sel_gen.sv
// tb_deint_sel_gen: directed self-checking bench for deint_sel_gen (3x4).
// Inputs change 1 ns after each rising edge; outputs are sampled 1 ns later.
module tb_deint_sel_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic [3:0] sel;
  logic       dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       frame_done;
`ifdef DEINT_BYPASS_EN
  logic       bypass;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-derived 3x4 write sel sequence.
  logic [3:0] sel_exp [12] = '{4'd1, 4'd5, 4'd9, 4'd2, 4'd6, 4'd10,
                               4'd3, 4'd7, 4'd11, 4'd4, 4'd8, 4'd12};
  // Input 0xA5C (k=0 is MSB) lands as buffer[0..11] = 1,0,0,1,0,0,1,0,1,1,1,0.
  logic [11:0] pat   = 12'hA5C;
  logic [11:0] rdexp = 12'h92E;

  always #5 clk = ~clk;

  deint_sel_gen #(
    .ROWS(3),
    .COLS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
`ifdef DEINT_BYPASS_EN
    .bypass    (bypass),
`endif
    .din_ready (din_ready),
    .sel       (sel),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .frame_done(frame_done)
  );

  function automatic logic [3:0] ix(input int unsigned k);
    return 4'(k);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held 2 cycles with din_valid=1: nothing may be written.
    rst = 1'b1; din = 1'b1; din_valid = 1'b1; dout_ready = 1'b0;
`ifdef DEINT_BYPASS_EN
    bypass = 1'b0;
`endif
    step();
    step();
    rst = 1'b0; din_valid = 1'b0; din = 1'b0;
    #1;
    chk1("rst_din_ready", din_ready, 1'b1);
    chk1("rst_dout_valid", dout_valid, 1'b0);
    chk4("rst_sel", sel, 4'd0);
    chk1("rst_frame_done", frame_done, 1'b0);
    chk1("rst_dout", dout, 1'b0);
    step();

    // Back-to-back writes of zeros: sel sequence.
    for (int unsigned k = 0; k < 12; k++) begin
      din_valid = 1'b1; din = 1'b0;
      #1;
      chk4("sel_seq", sel, sel_exp[ix(k)]);
      chk1("seq_din_ready", din_ready, 1'b1);
      step();
    end
    din_valid = 1'b0;
    #1;
    chk1("seq_dout_valid", dout_valid, 1'b1);
    chk1("seq_din_ready_low", din_ready, 1'b0);
    chk4("seq_sel_in_read", sel, 4'd0);
    step();
    dout_ready = 1'b1;
    for (int unsigned i = 0; i < 12; i++) begin
      #1;
      chk1("zero_frame_dout", dout, 1'b0);
      step();
    end
    dout_ready = 1'b0;
    #1;
    chk1("zero_frame_done", frame_done, 1'b1);
    step();

    // Permutation: single 1 at k=1 must emerge at read index 4.
    for (int unsigned k = 0; k < 12; k++) begin
      din_valid = 1'b1; din = (k == 1);
      step();
    end
    din_valid = 1'b0; dout_ready = 1'b1;
    for (int unsigned i = 0; i < 12; i++) begin
      #1;
      chk1("perm_dout", dout, (i == 4));
      chk1("perm_dout_valid", dout_valid, 1'b1);
      if (i < 11) chk1("perm_no_done", frame_done, 1'b0);
      step();
    end
    dout_ready = 1'b0;
    #1;
    chk1("perm_frame_done", frame_done, 1'b1);
    chk1("perm_din_ready_back", din_ready, 1'b1);
    chk1("perm_dout_valid_low", dout_valid, 1'b0);
    step();
    #1;
    chk1("perm_frame_done_pulse", frame_done, 1'b0);
    step();

    // Stalled write of 0xA5C with idle cycles; dout_ready during WRITE ignored.
    for (int unsigned k = 0; k < 12; k++) begin
      if (k % 3 == 1) begin
        din_valid = 1'b0; din = ~pat[ix(11 - k)]; dout_ready = 1'b1;
        #1;
        chk4("stall_idle_sel", sel, 4'd0);
        chk1("stall_write_no_dout_valid", dout_valid, 1'b0);
        step();
      end
      din_valid = 1'b1; din = pat[ix(11 - k)]; dout_ready = 1'b0;
      #1;
      chk4("stall_sel", sel, sel_exp[ix(k)]);
      step();
    end
    // Read with stalls; din_valid=1 throughout READ must be ignored.
    din_valid = 1'b1; din = 1'b1;
    for (int unsigned i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        dout_ready = 1'b0;
        #1;
        chk1("stall_read_dout", dout, rdexp[ix(11 - i)]);
        chk4("stall_read_sel", sel, 4'd0);
        chk1("stall_read_din_ready", din_ready, 1'b0);
        step();
      end
      dout_ready = 1'b1;
      #1;
      chk1("stall_read_dout_held", dout, rdexp[ix(11 - i)]);
      chk1("stall_read_dout_valid", dout_valid, 1'b1);
      step();
    end
    din_valid = 1'b0; dout_ready = 1'b0;
    #1;
    chk1("stall_frame_done", frame_done, 1'b1);
    step();

    // Reset after 7 writes, then a fresh frame of ones.
    for (int unsigned k = 0; k < 7; k++) begin
      din_valid = 1'b1; din = 1'b0;
      step();
    end
    rst = 1'b1; din_valid = 1'b0;
    step();
    rst = 1'b0;
    for (int unsigned k = 0; k < 12; k++) begin
      din_valid = 1'b1; din = 1'b1;
      #1;
      chk4("midrst_sel", sel, sel_exp[ix(k)]);
      if (k == 0) chk1("midrst_dout_valid", dout_valid, 1'b0);
      step();
    end
    din_valid = 1'b0; dout_ready = 1'b1;
    for (int unsigned i = 0; i < 12; i++) begin
      #1;
      chk1("midrst_dout", dout, 1'b1);
      step();
    end
    dout_ready = 1'b0;
    #1;
    chk1("midrst_frame_done", frame_done, 1'b1);
    step();

`ifdef DEINT_BYPASS_EN
    // Bypass: identity mapping, output order equals input order.
    bypass = 1'b1;
    for (int unsigned k = 0; k < 12; k++) begin
      din_valid = 1'b1; din = pat[ix(11 - k)];
      #1;
      chk4("bypass_sel", sel, ix(k + 1));
      step();
    end
    din_valid = 1'b0; dout_ready = 1'b1;
    for (int unsigned i = 0; i < 12; i++) begin
      #1;
      chk1("bypass_dout", dout, pat[ix(11 - i)]);
      step();
    end
    dout_ready = 1'b0; bypass = 1'b0;
    #1;
    chk1("bypass_frame_done", frame_done, 1'b1);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
